// File: rtl/m68k_bus_target_if.sv
// rtl/m68k_bus_target_if.sv - 68000 asynchronous bus signals between initiator and responder
interface m68k_bus_target_if;
  logic        M68K_AS_n;
  logic        M68K_UDS_n;
  logic        M68K_LDS_n;
  logic        M68K_RW;
  logic [23:1] M68K_A;
  logic [15:0] M68K_D_IN;
  logic [15:0] M68K_D_OUT;
  logic        M68K_D_OE;
  logic        M68K_DTACK_n;
  logic        M68K_BERR_n;

  modport master (
    output M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_A, M68K_D_IN,
    input  M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_BERR_n
  );

  modport slave (
    input  M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_A, M68K_D_IN,
    output M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_BERR_n
  );
endinterface

// File: rtl/m68k_bus_target.sv
// rtl/m68k_bus_target.sv - 68000 bus responder backing a word-wide RAM window, DTACK/BERR replies
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR   = 24'h200000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic                  i_c200m,
  input  logic                  i_reset,
  m68k_bus_target_if.slave      bus,
  output logic [15:0]           o_hit_count
);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_WAIT, S_ACK, S_ERR, S_REL} state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  state_t                 r_state;
  logic [3:0]             r_sync1;
  logic [3:0]             r_sync2;
  logic [3:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_idx;
  logic                   r_rw;
  logic                   r_uds_n;
  logic                   r_lds_n;
  logic                   r_dtack_n;
  logic                   r_berr_n;
  logic                   r_d_oe;
  logic [15:0]            r_d_out;
  logic [15:0]            r_hit_count;
  logic [15:0]            r_ram [0:(1<<ADDR_BITS)-1];

  logic                   w_as_s;
  logic                   w_uds_s;
  logic                   w_lds_s;
  logic                   w_rw_s;
  logic                   w_strobe;
  logic                   w_in_window;
  logic [ADDR_BITS-1:0]   w_idx;
  logic [ADDR_BITS-1:0]   w_rd_idx;
  logic [15:0]            w_rd_data;
  logic                   w_ram_we;

  assign w_as_s      = r_sync2[3];
  assign w_uds_s     = r_sync2[2];
  assign w_lds_s     = r_sync2[1];
  assign w_rw_s      = r_sync2[0];
  assign w_strobe    = !w_as_s && (!w_uds_s || !w_lds_s);
  assign w_in_window = (bus.M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
  assign w_idx       = bus.M68K_A[ADDR_BITS:1];
  // Zero-wait reads load read data straight from IDLE, so look up the live address there.
  assign w_rd_idx    = (r_state == S_IDLE) ? w_idx : r_idx;
  assign w_rd_data   = r_ram[w_rd_idx];
  assign w_ram_we    = !i_reset && (r_state == S_WAIT) && !w_as_s && (r_cnt == 4'd0) && !r_rw;

  assign bus.M68K_DTACK_n = r_dtack_n;
  assign bus.M68K_BERR_n  = r_berr_n;
  assign bus.M68K_D_OE    = r_d_oe;
  assign bus.M68K_D_OUT   = r_d_out;
  assign o_hit_count      = r_hit_count;

  // Synchronisers are deliberately not reset so DRAIN sees the true AS_n level right after reset.
  always_ff @(posedge i_c200m) begin
    r_sync1 <= {bus.M68K_AS_n, bus.M68K_UDS_n, bus.M68K_LDS_n, bus.M68K_RW};
    r_sync2 <= r_sync1;
  end

  always_ff @(posedge i_c200m) begin
    if (w_ram_we) begin
      if (!r_uds_n) r_ram[r_idx][15:8] <= bus.M68K_D_IN[15:8];
      if (!r_lds_n) r_ram[r_idx][7:0]  <= bus.M68K_D_IN[7:0];
    end
  end

  always_ff @(posedge i_c200m) begin
    if (i_reset) begin
      r_state     <= S_DRAIN;
      r_dtack_n   <= 1'b1;
      r_berr_n    <= 1'b1;
      r_d_oe      <= 1'b0;
      r_d_out     <= 16'h0000;
      r_hit_count <= 16'h0000;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_rw        <= 1'b1;
      r_uds_n     <= 1'b1;
      r_lds_n     <= 1'b1;
    end else begin
      case (r_state)
        S_DRAIN: if (w_as_s) r_state <= S_IDLE;
        S_IDLE: begin
          if (w_strobe) begin
            r_idx   <= w_idx;
            r_rw    <= w_rw_s;
            r_uds_n <= w_uds_s;
            r_lds_n <= w_lds_s;
            if (w_in_window) begin
              r_state <= S_WAIT;
              r_cnt   <= LP_WAIT;
              if (LP_WAIT == 4'd0 && w_rw_s) begin
                r_d_out <= w_rd_data;
                r_d_oe  <= 1'b1;
              end
            end else begin
              r_state  <= S_ERR;
              r_berr_n <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (w_as_s) begin
            r_state <= S_REL;
          end else if (r_cnt == 4'd0) begin
            r_state     <= S_ACK;
            r_dtack_n   <= 1'b0;
            r_hit_count <= r_hit_count + 16'd1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Drive read data one cycle ahead of DTACK_n so it is settled when the initiator latches.
            if (r_cnt == 4'd1 && r_rw) begin
              r_d_out <= w_rd_data;
              r_d_oe  <= 1'b1;
            end
          end
        end
        S_ACK: begin
          if (w_as_s) begin
            r_state   <= S_REL;
            r_dtack_n <= 1'b1;
          end
        end
        S_ERR: begin
          r_d_oe <= 1'b0;
          if (w_as_s) begin
            r_state  <= S_REL;
            r_berr_n <= 1'b1;
          end
        end
        S_REL: begin
          r_d_oe  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_DRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_target.sv
// tb/tb_m68k_bus_target.sv - directed bench for m68k_bus_target with immediate assertions
module tb_m68k_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] hit;
  int          errors = 0;
  int          checks = 0;
  int          lat;
  int          oe_at;
  int          seen;

  always #5 clk = ~clk;

  m68k_bus_target_if bus ();

  m68k_bus_target #(
    .BASE_ADDR   (24'h200000),
    .ADDR_BITS   (8),
    .WAIT_CYCLES (4)
  ) dut (
    .i_c200m     (clk),
    .i_reset     (rst),
    .bus         (bus),
    .o_hit_count (hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_cycle(input logic [23:0] addr, input logic rw, input logic uds_n,
                           input logic lds_n, input logic [15:0] d,
                           output int o_lat, output int o_oe_at);
    o_lat   = -1;
    o_oe_at = -1;
    @(negedge clk);
    bus.M68K_A     = addr[23:1];
    bus.M68K_D_IN  = d;
    bus.M68K_RW    = rw;
    bus.M68K_UDS_n = uds_n;
    bus.M68K_LDS_n = lds_n;
    bus.M68K_AS_n  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (o_oe_at < 0 && bus.M68K_D_OE) o_oe_at = n;
      if (!bus.M68K_DTACK_n || !bus.M68K_BERR_n) begin
        o_lat = n;
        break;
      end
    end
  endtask

  task automatic release_bus(output int o_lat);
    o_lat = -1;
    @(negedge clk);
    bus.M68K_AS_n  = 1'b1;
    bus.M68K_UDS_n = 1'b1;
    bus.M68K_LDS_n = 1'b1;
    bus.M68K_RW    = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.M68K_DTACK_n && bus.M68K_BERR_n) begin
        o_lat = n;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.M68K_AS_n  = 1'b1;
    bus.M68K_UDS_n = 1'b1;
    bus.M68K_LDS_n = 1'b1;
    bus.M68K_RW    = 1'b1;
    bus.M68K_A     = '0;
    bus.M68K_D_IN  = 16'h0000;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_dtack", 32'(bus.M68K_DTACK_n), 32'd1);
    chk("rst_berr",  32'(bus.M68K_BERR_n),  32'd1);
    chk("rst_oe",    32'(bus.M68K_D_OE),    32'd0);
    chk("rst_dout",  32'(bus.M68K_D_OUT),   32'h0);
    chk("rst_hit",   32'(hit),              32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Word write: 2 sync + 1 idle + 4 wait + 1 = 8 cycles to DTACK_n.
    bus_cycle(24'h200010, 1'b0, 1'b0, 1'b0, 16'hBEEF, lat, oe_at);
    chk("wr_lat",   32'(lat),   32'd8);
    chk("wr_no_oe", 32'(oe_at), 32'hFFFF_FFFF);
    chk("wr_hit",   32'(hit),   32'd1);
    release_bus(lat);
    chk("wr_rel",   32'(lat),   32'd3);

    bus_cycle(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, lat, oe_at);
    chk("rd_lat",  32'(lat),             32'd8);
    chk("rd_oe",   32'(oe_at),           32'd7);
    chk("rd_data", 32'(bus.M68K_D_OUT),  32'hBEEF);
    chk("rd_berr", 32'(bus.M68K_BERR_n), 32'd1);
    release_bus(lat);
    chk("rd_rel",    32'(lat),           32'd3);
    chk("rd_oe_off", 32'(bus.M68K_D_OE), 32'd0);
    chk("rd_hit",    32'(hit),           32'd2);

    bus_cycle(24'h200011, 1'b0, 1'b1, 1'b0, 16'h1234, lat, oe_at);
    chk("bw_lat", 32'(lat), 32'd8);
    release_bus(lat);
    bus_cycle(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, lat, oe_at);
    chk("bw_data", 32'(bus.M68K_D_OUT), 32'hBE34);
    release_bus(lat);
    chk("bw_hit", 32'(hit), 32'd4);

    bus_cycle(24'h300000, 1'b1, 1'b0, 1'b0, 16'h0000, lat, oe_at);
    chk("oow_lat",   32'(lat),              32'd3);
    chk("oow_berr",  32'(bus.M68K_BERR_n),  32'd0);
    chk("oow_dtack", 32'(bus.M68K_DTACK_n), 32'd1);
    chk("oow_oe",    32'(bus.M68K_D_OE),    32'd0);
    chk("oow_hit",   32'(hit),              32'd4);
    release_bus(lat);
    chk("oow_rel",   32'(lat),              32'd3);

    // Abort: AS_n rises while the write is still counting down.
    bus_cycle(24'h200012, 1'b0, 1'b0, 1'b0, 16'h1111, lat, oe_at);
    release_bus(lat);
    @(negedge clk);
    bus.M68K_A     = 23'h100009;
    bus.M68K_D_IN  = 16'h5555;
    bus.M68K_RW    = 1'b0;
    bus.M68K_UDS_n = 1'b0;
    bus.M68K_LDS_n = 1'b0;
    bus.M68K_AS_n  = 1'b0;
    repeat (3) @(negedge clk);
    bus.M68K_AS_n  = 1'b1;
    bus.M68K_UDS_n = 1'b1;
    bus.M68K_LDS_n = 1'b1;
    bus.M68K_RW    = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (!bus.M68K_DTACK_n) seen = 1;
    end
    chk("abort_dtack", 32'(seen), 32'd0);
    chk("abort_hit",   32'(hit),  32'd5);
    bus_cycle(24'h200012, 1'b1, 1'b0, 1'b0, 16'h0000, lat, oe_at);
    chk("abort_data", 32'(bus.M68K_D_OUT), 32'h1111);
    release_bus(lat);

    // Reset during WAIT with AS_n held low: no answer until a fresh cycle.
    @(negedge clk);
    bus.M68K_A     = 23'h100008;
    bus.M68K_D_IN  = 16'hDEAD;
    bus.M68K_RW    = 1'b0;
    bus.M68K_UDS_n = 1'b0;
    bus.M68K_LDS_n = 1'b0;
    bus.M68K_AS_n  = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_dtack", 32'(bus.M68K_DTACK_n), 32'd1);
    chk("mid_rst_berr",  32'(bus.M68K_BERR_n),  32'd1);
    chk("mid_rst_oe",    32'(bus.M68K_D_OE),    32'd0);
    chk("mid_rst_hit",   32'(hit),              32'd0);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!bus.M68K_DTACK_n || !bus.M68K_BERR_n) seen = 1;
    end
    chk("drain_quiet", 32'(seen), 32'd0);
    release_bus(lat);
    repeat (2) @(negedge clk);
    bus_cycle(24'h200010, 1'b1, 1'b0, 1'b0, 16'h0000, lat, oe_at);
    chk("post_rst_lat",  32'(lat),             32'd8);
    chk("post_rst_data", 32'(bus.M68K_D_OUT),  32'hBE34);
    release_bus(lat);
    chk("post_rst_hit",  32'(hit),             32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
